row_window_loader: RTL and testbench

Streaming front end for the border-detection datapath. Accepts a raster-order 8-bit grayscale pixel stream over a valid/ready handshake and assembles the three-row window (`row1`, `row2`, `row3`) that the border detector consumes. After each new full row arrives, it shifts the window and presents it until the detector accepts it. It produces exactly the row-parallel window the detector expects, one window per image row from the third row onward.

---
 rtl/row_window_loader.sv | 119 +++++++++++
 tb/tb_row_window_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_window_loader.sv
// Three-row window assembler for the border detector: buffers one raster row,
// shifts it into a row1/row2/row3 window and holds that window until accepted.
module row_window_loader #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned PIX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [PIX_W-1:0]         s_data,
    input  logic                     s_sof,
    output logic [WIDTH*PIX_W-1:0]   row1,
    output logic [WIDTH*PIX_W-1:0]   row2,
    output logic [WIDTH*PIX_W-1:0]   row3,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [7:0]               win_row,
    output logic                     frame_done
);

    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = WIDTH * PIX_W;

    localparam logic [1:0] LOAD    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_eff;
    logic [7:0]       rcnt;
    logic [1:0]       fill;
    logic [1:0]       fill_inc;
    logic [ROW_W-1:0] stage;
    logic             pix_acc;
    logic             win_acc;
    logic             row_end;
    logic             frame_end;

    // Handshake decode and next-state logic; a start-of-frame pixel lands in column 0.
    always_comb begin
        col_eff    = s_sof ? '0 : col;
        pix_acc    = s_valid && s_ready;
        win_acc    = win_valid && win_ready;
        row_end    = pix_acc && (col_eff == COL_W'(WIDTH - 1));
        fill_inc   = (fill == 2'd3) ? 2'd3 : fill + 2'd1;
        frame_end  = win_acc && (rcnt == 8'(HEIGHT));
        state_next = state;
        case (state)
            LOAD:    if (row_end) state_next = SHIFT;
            SHIFT:   state_next = (fill_inc == 2'd3) ? PRESENT : LOAD;
            PRESENT: if (win_acc) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // State register; handshake flags are registered images of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            s_ready    <= 1'b1;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            s_ready    <= (state_next == LOAD);
            win_valid  <= (state_next == PRESENT);
            frame_done <= frame_end;
        end
    end

    // Column, row and fill bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            rcnt    <= '0;
            fill    <= '0;
            win_row <= '0;
        end else begin
            if (pix_acc) begin
                col <= row_end ? '0 : col_eff + COL_W'(1);
                if (s_sof) begin
                    rcnt <= '0;
                    fill <= '0;
                end
            end
            if (state == SHIFT) begin
                rcnt    <= rcnt + 8'd1;
                fill    <= fill_inc;
                win_row <= rcnt - 8'd1;
            end
            if (frame_end) begin
                rcnt <= '0;
                fill <= '0;
            end
        end
    end

    // Row staging buffer and the three-row window shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
            row1  <= '0;
            row2  <= '0;
            row3  <= '0;
        end else begin
            if (pix_acc) stage[32'(col_eff) * PIX_W +: PIX_W] <= s_data;
            if (state == SHIFT) begin
                row1 <= row2;
                row2 <= row3;
                row3 <= stage;
            end
        end
    end

endmodule

// File: tb/tb_row_window_loader.sv
// Randomized bench for row_window_loader against a row-list reference model,
// using a reduced frame size so whole frames fit in a short run.
module tb_row_window_loader;

    localparam int unsigned W     = 24;
    localparam int unsigned H     = 10;
    localparam int unsigned P     = 8;
    localparam int unsigned ROW_W = W * P;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [P-1:0]     s_data;
    logic             s_sof;
    logic [ROW_W-1:0] row1;
    logic [ROW_W-1:0] row2;
    logic [ROW_W-1:0] row3;
    logic             win_valid;
    logic             win_ready;
    logic [7:0]       win_row;
    logic             frame_done;

    row_window_loader #(.WIDTH(W), .HEIGHT(H), .PIX_W(P)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .row1(row1), .row2(row2), .row3(row3),
        .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROW_W-1:0] r1;
        logic [ROW_W-1:0] r2;
        logic [ROW_W-1:0] r3;
        logic [7:0]       wrow;
        bit               fin;
        int               due;
    } win_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mx, my, last_row_cyc, fd_cyc;
    int win_cnt = 0;
    int fd_cnt = 0;
    int last_win_row = 0;
    bit ff_on = 1'b0;
    int ff_idx = 0;
    logic [ROW_W-1:0] h1, h2, h3, cur;
    win_t wq[$];

    task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [ROW_W-1:0] rep(input logic [7:0] b);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < int'(W); i++) r[i*P +: P] = b;
        return r;
    endfunction

    task automatic model_reset();
        h1 = '0; h2 = '0; h3 = '0; cur = '0;
        mx = 0; my = 0;
        wq.delete();
        last_row_cyc = -10;
        fd_cyc = -10;
    endtask

    // Reference: rows are collected whole; every completed row from the third
    // of a frame onward yields the window of the last three rows, visible two cycles later.
    task automatic model_pixel(input logic [7:0] d, input bit sof);
        if (sof) begin
            mx = 0;
            my = 0;
        end
        cur[mx*P +: P] = d;
        mx++;
        if (mx == int'(W)) begin
            mx = 0;
            my++;
            h1 = h2; h2 = h3; h3 = cur;
            last_row_cyc = cyc;
            if (my >= 3) wq.push_back('{h1, h2, h3, 8'(my - 2), (my == int'(H)), cyc + 2});
            if (my == int'(H)) my = 0;
        end
    endtask

    task automatic step(input bit v, input bit sof, input bit wr, input int mode, output bit acc);
        logic [7:0] d;
        int px, py;
        bit pend, exp_wv, exp_sr;
        px = sof ? 0 : mx;
        py = sof ? 0 : my;
        case (mode)
            0:       d = 8'(py);
            1:       d = 8'(px + py);
            default: d = 8'($urandom);
        endcase
        s_valid = v; s_sof = sof; s_data = d; win_ready = wr;
        pend   = wq.size() > 0;
        exp_wv = pend && (cyc >= wq[0].due);
        exp_sr = !exp_wv && (cyc != last_row_cyc + 1);
        check("s_ready", ROW_W'(s_ready), ROW_W'(exp_sr));
        check("win_valid", ROW_W'(win_valid), ROW_W'(exp_wv));
        check("frame_done", ROW_W'(frame_done), ROW_W'(cyc == fd_cyc));
        if (frame_done) fd_cnt++;
        if (win_valid && pend) begin
            check("row1", row1, wq[0].r1);
            check("row2", row2, wq[0].r2);
            check("row3", row3, wq[0].r3);
            check("win_row", ROW_W'(win_row), ROW_W'(wq[0].wrow));
        end
        acc = v && s_ready;
        if (win_valid && wr) begin
            win_cnt++;
            last_win_row = int'(win_row);
            if (ff_on) begin
                check("ff_win_row", ROW_W'(win_row), ROW_W'(ff_idx + 1));
                check("ff_row2_px7", ROW_W'(row2[7*P +: P]), ROW_W'(8'(7 + ff_idx + 1)));
                ff_idx++;
            end
            if (pend) begin
                if (wq[0].fin) fd_cyc = cyc + 1;
                void'(wq.pop_front());
            end
        end
        if (acc) model_pixel(d, sof);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_pixels(input int n, input int vp, input int rp, input int mode, input bit sof_first);
        int acc_n = 0;
        int budget = 0;
        bit first = sof_first;
        bit v, a;
        while (acc_n < n && budget < 20 * n + 200) begin
            v = int'($urandom_range(99)) < vp;
            step(v, first && v, int'($urandom_range(99)) < rp, mode, a);
            if (a) begin
                acc_n++;
                first = 1'b0;
            end
            budget++;
        end
        if (acc_n < n) check("run_timeout", ROW_W'(acc_n), ROW_W'(n));
    endtask

    task automatic drain(input int rp);
        int budget = 0;
        bit a;
        while ((wq.size() > 0 || cyc <= last_row_cyc + 1 || cyc <= fd_cyc) && budget < 1000) begin
            step(1'b0, 1'b0, int'($urandom_range(99)) < rp, 0, a);
            budget++;
        end
        if (budget >= 1000) check("drain_timeout", ROW_W'(wq.size()), '0);
    endtask

    task automatic wait_window();
        int n = 0;
        bit a;
        while (!win_valid && n < 10) begin
            step(1'b0, 1'b0, 1'b0, 0, a);
            n++;
        end
        check("window_wait", ROW_W'(win_valid), ROW_W'(1));
    endtask

    int wc0, fd0;
    bit a;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; win_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_s_ready", ROW_W'(s_ready), ROW_W'(1));
        check("rst_win_valid", ROW_W'(win_valid), '0);
        check("rst_frame_done", ROW_W'(frame_done), '0);
        check("rst_win_row", ROW_W'(win_row), '0);
        check("rst_row1", row1, '0);
        check("rst_row3", row3, '0);
        rst_n = 1'b1;
        cyc = 0;

        // Fill: three rows of constant row index, detector stalled.
        run_pixels(3 * int'(W), 100, 0, 0, 1'b0);
        wait_window();
        check("fill_latency", ROW_W'(cyc), ROW_W'(last_row_cyc + 2));
        check("fill_row1", row1, rep(8'h00));
        check("fill_row2", row2, rep(8'h01));
        check("fill_row3", row3, rep(8'h02));
        check("fill_win_row", ROW_W'(win_row), ROW_W'(1));
        check("fill_s_ready", ROW_W'(s_ready), '0);

        // Backpressure hold then accept.
        repeat (10) step(1'b1, 1'b0, 1'b0, 0, a);
        check("bp_rows_held", row2, rep(8'h01));
        step(1'b0, 1'b0, 1'b1, 0, a);
        check("bp_s_ready_after", ROW_W'(s_ready), ROW_W'(1));

        // Full frame with gradient pixels and an always-ready detector.
        wc0 = win_cnt; fd0 = fd_cnt; ff_on = 1'b1; ff_idx = 0;
        run_pixels(int'(W * H), 100, 100, 1, 1'b1);
        drain(100);
        ff_on = 1'b0;
        check("ff_windows", ROW_W'(win_cnt - wc0), ROW_W'(H - 2));
        check("ff_frame_done", ROW_W'(fd_cnt - fd0), ROW_W'(1));

        // Next frame: nothing before its third row completes.
        wc0 = win_cnt;
        run_pixels(3 * int'(W) - 1, 100, 100, 1, 1'b0);
        drain(100);
        check("nf_no_early", ROW_W'(win_cnt - wc0), '0);
        run_pixels(1, 100, 100, 1, 1'b0);
        drain(100);
        check("nf_first", ROW_W'(win_cnt - wc0), ROW_W'(1));
        check("nf_first_row", ROW_W'(last_win_row), ROW_W'(1));

        // Random stalls over two frames.
        wc0 = win_cnt; fd0 = fd_cnt;
        run_pixels(2 * int'(W * H), 70, 60, 2, 1'b1);
        drain(60);
        check("rnd_windows", ROW_W'(win_cnt - wc0), ROW_W'(2 * (H - 2)));
        check("rnd_frame_done", ROW_W'(fd_cnt - fd0), ROW_W'(2));

        // Resync mid row 5.
        run_pixels(5 * int'(W) + int'(W) / 2, 100, 100, 2, 1'b1);
        wc0 = win_cnt;
        run_pixels(3 * int'(W), 100, 100, 2, 1'b1);
        drain(100);
        check("resync_windows", ROW_W'(win_cnt - wc0), ROW_W'(1));
        check("resync_win_row", ROW_W'(last_win_row), ROW_W'(1));

        // Async reset while a window is presented.
        run_pixels(3 * int'(W), 100, 0, 2, 1'b1);
        wait_window();
        rst_n = 1'b0;
        #1;
        check("ar_s_ready", ROW_W'(s_ready), ROW_W'(1));
        check("ar_win_valid", ROW_W'(win_valid), '0);
        check("ar_win_row", ROW_W'(win_row), '0);
        check("ar_row1", row1, '0);
        check("ar_row2", row2, '0);
        check("ar_row3", row3, '0);
        model_reset();
        repeat (3) @(negedge clk);
        cyc += 3;
        rst_n = 1'b1;
        wc0 = win_cnt;
        run_pixels(3 * int'(W), 100, 100, 0, 1'b0);
        drain(100);
        check("ar_refill_windows", ROW_W'(win_cnt - wc0), ROW_W'(1));
        check("ar_refill_row", ROW_W'(last_win_row), ROW_W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
